// File: rtl/ex_hilo_muldiv.sv
// ex_hilo_muldiv: execute-stage HI/LO unit.
//   Owns the architectural HI/LO registers. MTHI/MTLO and MULT/MULTU write
//   them at the accept edge. DIV/DIVU run an iterative radix-2 restoring
//   divider that holds the pipeline while it works. MFHI/MFLO read HI/LO
//   combinationally.
// Ports:
//   clk, rst             clock and asynchronous active-high reset
//   valid_i, flush_i     EX holds a real instruction / pipeline flush
//   aluop_i              operation subtype from decode
//   reg1_i, reg2_i       operand 1 (dividend/multiplicand/MTxx source), operand 2
//   stallreq_o           freeze IF/ID/EX while a divide is in flight
//   hilo_rdata_o         HI for MFHI, LO for MFLO, otherwise 0
//   hi_o, lo_o           current HI and LO register values
module ex_hilo_muldiv #(
  parameter int DATA_W     = 32,
  parameter int DIV_CYCLES = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic              flush_i,
  input  logic [7:0]        aluop_i,
  input  logic [DATA_W-1:0] reg1_i,
  input  logic [DATA_W-1:0] reg2_i,
  output logic              stallreq_o,
  output logic [DATA_W-1:0] hilo_rdata_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  // Decode subtype codes for the HI/LO group.
  localparam logic [7:0] OP_MFHI  = 8'b0001_0000;
  localparam logic [7:0] OP_MTHI  = 8'b0001_0001;
  localparam logic [7:0] OP_MFLO  = 8'b0001_0010;
  localparam logic [7:0] OP_MTLO  = 8'b0001_0011;
  localparam logic [7:0] OP_MULT  = 8'b0001_1000;
  localparam logic [7:0] OP_MULTU = 8'b0001_1001;
  localparam logic [7:0] OP_DIV   = 8'b0001_1010;
  localparam logic [7:0] OP_DIVU  = 8'b0001_1011;

  localparam int                CNT_W    = $clog2(DIV_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Two's complement negation.
  function automatic logic [DATA_W-1:0] f_neg(input logic [DATA_W-1:0] v);
    f_neg = ~v + {{(DATA_W-1){1'b0}}, 1'b1};
  endfunction

  // Magnitude of a signed value; the most negative value maps to itself,
  // which is the correct unsigned magnitude.
  function automatic logic [DATA_W-1:0] f_abs(input logic [DATA_W-1:0] v);
    if (v[DATA_W-1]) f_abs = f_neg(v);
    else             f_abs = v;
  endfunction

  state_t              r_state, w_state_nxt;
  logic [DATA_W-1:0]   r_hi, r_lo;
  logic [DATA_W-1:0]   r_rem, r_quo, r_dvsr;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_neg_quo, r_neg_rem;

  logic                w_accept, w_is_div, w_is_sdiv, w_div_zero, w_div_start;
  logic                w_is_smul;
  logic [2*DATA_W-1:0] w_m1, w_m2, w_prod;
  logic [DATA_W:0]     w_shift;
  logic [DATA_W-1:0]   w_trial;
  logic                w_trial_ok;
  logic [DATA_W-1:0]   w_quo_fin, w_rem_fin;
  logic                w_hi_we, w_lo_we;
  logic [DATA_W-1:0]   w_hi_d, w_lo_d;

  assign w_accept    = valid_i & ~flush_i & ~rst & (r_state == ST_IDLE);
  assign w_is_sdiv   = (aluop_i == OP_DIV);
  assign w_is_div    = w_is_sdiv | (aluop_i == OP_DIVU);
  assign w_div_zero  = (reg2_i == {DATA_W{1'b0}});
  assign w_div_start = w_accept & w_is_div & ~w_div_zero;

  // One shared multiplier: operands sign- or zero-extended to 2*DATA_W so the
  // low half of the wide product is the exact 64-bit result either way.
  assign w_is_smul = (aluop_i == OP_MULT);
  assign w_m1   = w_is_smul ? {{DATA_W{reg1_i[DATA_W-1]}}, reg1_i} : {{DATA_W{1'b0}}, reg1_i};
  assign w_m2   = w_is_smul ? {{DATA_W{reg2_i[DATA_W-1]}}, reg2_i} : {{DATA_W{1'b0}}, reg2_i};
  assign w_prod = w_m1 * w_m2;

  // Restoring step: the partial remainder stays below the divisor, so when the
  // shifted value reaches DATA_W+1 bits the subtraction always succeeds.
  assign w_shift    = {r_rem, r_quo[DATA_W-1]};
  assign w_trial_ok = (w_shift >= {1'b0, r_dvsr});
  assign w_trial    = w_shift[DATA_W-1:0] - r_dvsr;

  assign w_quo_fin = r_neg_quo ? f_neg(r_quo) : r_quo;
  assign w_rem_fin = r_neg_rem ? f_neg(r_rem) : r_rem;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // FSM next state and stall request; flush wins over everything.
  always_comb begin
    w_state_nxt = r_state;
    stallreq_o  = 1'b0;
    if (rst || flush_i) begin
      w_state_nxt = ST_IDLE;
      stallreq_o  = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_div_start) begin
            w_state_nxt = ST_RUN;
            stallreq_o  = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_RUN: begin
          stallreq_o = 1'b1;
          if (r_cnt == LAST_CNT) w_state_nxt = ST_DONE;
          else                   w_state_nxt = ST_RUN;
        end
        // Not IDLE here, so the DIV still on aluop_i cannot restart.
        ST_DONE: w_state_nxt = ST_IDLE;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Divider datapath: operand latch on issue, one restoring step per RUN cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rem     <= {DATA_W{1'b0}};
      r_quo     <= {DATA_W{1'b0}};
      r_dvsr    <= {DATA_W{1'b0}};
      r_cnt     <= {CNT_W{1'b0}};
      r_neg_quo <= 1'b0;
      r_neg_rem <= 1'b0;
    end else if (w_div_start) begin
      r_rem     <= {DATA_W{1'b0}};
      r_quo     <= w_is_sdiv ? f_abs(reg1_i) : reg1_i;
      r_dvsr    <= w_is_sdiv ? f_abs(reg2_i) : reg2_i;
      r_cnt     <= {CNT_W{1'b0}};
      r_neg_quo <= w_is_sdiv & (reg1_i[DATA_W-1] ^ reg2_i[DATA_W-1]);
      r_neg_rem <= w_is_sdiv & reg1_i[DATA_W-1];
    end else if (r_state == ST_RUN) begin
      r_rem <= w_trial_ok ? w_trial : w_shift[DATA_W-1:0];
      r_quo <= {r_quo[DATA_W-2:0], w_trial_ok};
      r_cnt <= r_cnt + CNT_ONE;
    end
  end

  // HI/LO write selection: divide completion, or an accepted write-type op.
  always_comb begin
    w_hi_we = 1'b0;
    w_lo_we = 1'b0;
    w_hi_d  = {DATA_W{1'b0}};
    w_lo_d  = {DATA_W{1'b0}};
    if (r_state == ST_DONE && !flush_i && !rst) begin
      w_hi_we = 1'b1;
      w_lo_we = 1'b1;
      w_hi_d  = w_rem_fin;
      w_lo_d  = w_quo_fin;
    end else if (w_accept) begin
      case (aluop_i)
        OP_MTHI: begin
          w_hi_we = 1'b1;
          w_hi_d  = reg1_i;
        end
        OP_MTLO: begin
          w_lo_we = 1'b1;
          w_lo_d  = reg1_i;
        end
        OP_MULT, OP_MULTU: begin
          w_hi_we = 1'b1;
          w_lo_we = 1'b1;
          w_hi_d  = w_prod[2*DATA_W-1:DATA_W];
          w_lo_d  = w_prod[DATA_W-1:0];
        end
        OP_DIV, OP_DIVU: begin
          // Divide by zero resolves in the issue cycle without stalling.
          if (w_div_zero) begin
            w_hi_we = 1'b1;
            w_lo_we = 1'b1;
            w_hi_d  = reg1_i;
            w_lo_d  = {DATA_W{1'b1}};
          end else begin
            w_hi_we = 1'b0;
            w_lo_we = 1'b0;
          end
        end
        default: begin
          w_hi_we = 1'b0;
          w_lo_we = 1'b0;
        end
      endcase
    end else begin
      w_hi_we = 1'b0;
      w_lo_we = 1'b0;
    end
  end

  // Architectural HI/LO registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hi <= {DATA_W{1'b0}};
      r_lo <= {DATA_W{1'b0}};
    end else begin
      if (w_hi_we) r_hi <= w_hi_d;
      if (w_lo_we) r_lo <= w_lo_d;
    end
  end

  // MFHI/MFLO read port.
  always_comb begin
    hilo_rdata_o = {DATA_W{1'b0}};
    case (aluop_i)
      OP_MFHI: hilo_rdata_o = r_hi;
      OP_MFLO: hilo_rdata_o = r_lo;
      default: hilo_rdata_o = {DATA_W{1'b0}};
    endcase
  end

  assign hi_o = r_hi;
  assign lo_o = r_lo;

endmodule

// File: tb/tb_ex_hilo_muldiv.sv
// Self-checking bench for ex_hilo_muldiv: arithmetic reference model plus a
// per-cycle compare process, and literal expectations for directed cases.
module tb_ex_hilo_muldiv;

  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_MFHI  = 8'b0001_0000;
  localparam logic [7:0] OP_MTHI  = 8'b0001_0001;
  localparam logic [7:0] OP_MFLO  = 8'b0001_0010;
  localparam logic [7:0] OP_MTLO  = 8'b0001_0011;
  localparam logic [7:0] OP_MULT  = 8'b0001_1000;
  localparam logic [7:0] OP_MULTU = 8'b0001_1001;
  localparam logic [7:0] OP_DIV   = 8'b0001_1010;
  localparam logic [7:0] OP_DIVU  = 8'b0001_1011;

  logic        clk;
  logic        rst;
  logic        valid_i;
  logic        flush_i;
  logic [7:0]  aluop_i;
  logic [31:0] reg1_i;
  logic [31:0] reg2_i;
  logic        stallreq_o;
  logic [31:0] hilo_rdata_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state.
  logic [31:0] m_hi = 32'h0;
  logic [31:0] m_lo = 32'h0;
  logic [31:0] m_res_hi = 32'h0;
  logic [31:0] m_res_lo = 32'h0;
  int          m_div_left = 0;   // stalled divide cycles still to come after issue
  bit          m_done = 1'b0;    // result commits on the coming edge

  ex_hilo_muldiv #(.DATA_W(32), .DIV_CYCLES(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .valid_i      (valid_i),
    .flush_i      (flush_i),
    .aluop_i      (aluop_i),
    .reg1_i       (reg1_i),
    .reg2_i       (reg2_i),
    .stallreq_o   (stallreq_o),
    .hilo_rdata_o (hilo_rdata_o),
    .hi_o         (hi_o),
    .lo_o         (lo_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] mul_model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sgn) return 64'(sa * sb);
    else     return {32'h0, a} * {32'h0, b};
  endfunction

  function automatic logic [31:0] divq_model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q  = sa / sb;
    if (sgn) return q[31:0];
    else     return a / b;
  endfunction

  function automatic logic [31:0] divr_model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = sa % sb;
    if (sgn) return r[31:0];
    else     return a % b;
  endfunction

  // Reference model: a non-zero divide stalls 32 cycles after issue, then
  // commits its result one cycle later.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_hi <= 32'h0; m_lo <= 32'h0; m_div_left <= 0; m_done <= 1'b0;
    end else if (flush_i) begin
      m_div_left <= 0; m_done <= 1'b0;
    end else if (m_done) begin
      m_hi <= m_res_hi; m_lo <= m_res_lo; m_done <= 1'b0;
    end else if (m_div_left > 1) begin
      m_div_left <= m_div_left - 1;
    end else if (m_div_left == 1) begin
      m_div_left <= 0; m_done <= 1'b1;
    end else if (valid_i) begin
      case (aluop_i)
        OP_MTHI:  m_hi <= reg1_i;
        OP_MTLO:  m_lo <= reg1_i;
        OP_MULT:  {m_hi, m_lo} <= mul_model(1'b1, reg1_i, reg2_i);
        OP_MULTU: {m_hi, m_lo} <= mul_model(1'b0, reg1_i, reg2_i);
        OP_DIV, OP_DIVU: begin
          if (reg2_i == 32'h0) begin
            m_hi <= reg1_i; m_lo <= 32'hFFFF_FFFF;
          end else begin
            m_res_lo   <= divq_model(aluop_i == OP_DIV, reg1_i, reg2_i);
            m_res_hi   <= divr_model(aluop_i == OP_DIV, reg1_i, reg2_i);
            m_div_left <= 32;
          end
        end
        default: ;
      endcase
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    logic        exp_stall;
    logic [31:0] exp_rd;
    exp_stall = !rst && !flush_i &&
                ((m_div_left > 0) ||
                 (m_div_left == 0 && !m_done && valid_i &&
                  (aluop_i == OP_DIV || aluop_i == OP_DIVU) && reg2_i != 32'h0));
    exp_rd = (aluop_i == OP_MFHI) ? m_hi : (aluop_i == OP_MFLO) ? m_lo : 32'h0;
    check("cyc_stall", {31'h0, stallreq_o}, {31'h0, exp_stall});
    check("cyc_hi", hi_o, m_hi);
    check("cyc_lo", lo_o, m_lo);
    check("cyc_rdata", hilo_rdata_o, exp_rd);
  end

  task automatic drive(input bit v, input logic [7:0] op, input logic [31:0] a,
                       input logic [31:0] b, input bit fl);
    valid_i = v; aluop_i = op; reg1_i = a; reg2_i = b; flush_i = fl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    drive(1'b1, op, a, b, 1'b0);
    step();
    drive(1'b0, OP_NOP, 32'h0, 32'h0, 1'b0);
  endtask

  // Hold the divide on the inputs until the first non-stalled cycle has passed.
  task automatic run_div(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int stalls);
    bit fin;
    stalls = 0;
    fin = 1'b0;
    drive(1'b1, op, a, b, 1'b0);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (stallreq_o) begin
        stalls++;
        step();
      end else begin
        step();
        fin = 1'b1;
        break;
      end
    end
    drive(1'b0, OP_NOP, 32'h0, 32'h0, 1'b0);
    if (!fin) begin
      n_cmp++; n_bad++;
      $display("FAIL div_timeout: stall still high after 100 cycles, required release");
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ns;
    rst = 1'b1;
    drive(1'b0, OP_NOP, 32'h0, 32'h0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_stall", {31'h0, stallreq_o}, 32'h0);
    check("rst_hi", hi_o, 32'h0);
    check("rst_lo", lo_o, 32'h0);
    step();
    rst = 1'b0;
    step();

    // MTHI then MFHI
    do_op(OP_MTHI, 32'h1234_5678, 32'h0);
    drive(1'b1, OP_MFHI, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    check("mfhi_rdata", hilo_rdata_o, 32'h1234_5678);
    check("mthi_lo", lo_o, 32'h0);
    step();

    // Multiplies
    do_op(OP_MULT, 32'hFFFF_FFFE, 32'h0000_0003);
    check("mult_hi", hi_o, 32'hFFFF_FFFF);
    check("mult_lo", lo_o, 32'hFFFF_FFFA);
    do_op(OP_MULTU, 32'hFFFF_FFFE, 32'h0000_0003);
    check("multu_hi", hi_o, 32'h0000_0002);
    check("multu_lo", lo_o, 32'hFFFF_FFFA);
    drive(1'b1, OP_MFLO, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    check("mflo_rdata", hilo_rdata_o, 32'hFFFF_FFFA);
    step();
    drive(1'b0, OP_NOP, 32'h0, 32'h0, 1'b0);

    // Divides
    run_div(OP_DIV, 32'hFFFF_FFF9, 32'h2, ns);
    check("div_stalls", 32'(ns), 32'd33);
    check("div_lo", lo_o, 32'hFFFF_FFFD);
    check("div_hi", hi_o, 32'hFFFF_FFFF);
    step();
    run_div(OP_DIVU, 32'd100, 32'd7, ns);
    check("divu_stalls", 32'(ns), 32'd33);
    check("divu_lo", lo_o, 32'd14);
    check("divu_hi", hi_o, 32'd2);
    run_div(OP_DIVU, 32'd5, 32'd0, ns);
    check("divz_stalls", 32'(ns), 32'd0);
    check("divz_hi", hi_o, 32'd5);
    check("divz_lo", lo_o, 32'hFFFF_FFFF);
    run_div(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, ns);
    check("divovf_lo", lo_o, 32'h8000_0000);
    check("divovf_hi", hi_o, 32'h0);

    // Flush at RUN cycle 10
    do_op(OP_MTHI, 32'hAAAA, 32'h0);
    do_op(OP_MTLO, 32'hBBBB, 32'h0);
    drive(1'b1, OP_DIVU, 32'd100, 32'd7, 1'b0);
    step();
    repeat (9) step();
    drive(1'b1, OP_DIVU, 32'd100, 32'd7, 1'b1);
    @(negedge clk);
    check("flush_stall", {31'h0, stallreq_o}, 32'h0);
    step();
    check("flush_hi", hi_o, 32'hAAAA);
    check("flush_lo", lo_o, 32'hBBBB);
    drive(1'b1, OP_MTLO, 32'h1, 32'h0, 1'b0);
    @(negedge clk);
    check("post_flush_stall", {31'h0, stallreq_o}, 32'h0);
    step();
    drive(1'b0, OP_NOP, 32'h0, 32'h0, 1'b0);
    check("post_flush_lo", lo_o, 32'h1);
    check("post_flush_hi", hi_o, 32'hAAAA);

    // Asynchronous reset mid-RUN
    drive(1'b1, OP_DIVU, 32'd100, 32'd7, 1'b0);
    repeat (5) step();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_stall", {31'h0, stallreq_o}, 32'h0);
    check("arst_hi", hi_o, 32'h0);
    check("arst_lo", lo_o, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1'b0, OP_NOP, 32'h0, 32'h0, 1'b0);
    step();
    run_div(OP_DIVU, 32'd9, 32'd3, ns);
    check("arst_divu_lo", lo_o, 32'd3);
    check("arst_divu_hi", hi_o, 32'd0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ex_hilo_muldiv.md
Name: ex_hilo_muldiv

Overview:
- Execute-stage consumer of the decode outputs (valid, aluop, operand 1, operand 2) for the HI/LO instruction group.
- Owns the architectural HI/LO registers.
- Performs MULT/MULTU in a single cycle and DIV/DIVU with an iterative radix-2 divider.
- Raises a pipeline stall request while a divide is in flight, and returns HI/LO contents for MFHI/MFLO.

Parameters:
- DATA_W, 32, operand and HI/LO width
- DIV_CYCLES, 32, iteration count of the divider (equal to DATA_W)

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous reset, active-high
- valid_i  input  1  EX stage holds a real instruction this cycle
- flush_i  input  1  pipeline flush; aborts any in-flight divide
- aluop_i  input  8  operation subtype from decode (codes from the shared defines header)
- reg1_i  input  32  operand 1: dividend / multiplicand / MTHI/MTLO source
- reg2_i  input  32  operand 2: divisor / multiplier
- stallreq_o  output  1  hold the pipeline (IF/ID/EX frozen)
- hilo_rdata_o  output  32  MFHI returns hi_q, MFLO returns lo_q, otherwise 0 (combinational)
- hi_o  output  32  current HI register
- lo_o  output  32  current LO register

Behaviour:
- Reset: asynchronous and active-high. Sets hi_q, lo_q, divider state, counter and datapath registers to 0, and the FSM to IDLE. stallreq_o=0 and hilo_rdata_o=0 during reset.
- "Accept" means valid_i=1, flush_i=0 and FSM=IDLE.
- MTHI on accept: hi_q<=reg1_i at the clock edge.
- MTLO on accept: lo_q<=reg1_i at the clock edge.
- MULTU on accept: {hi_q,lo_q}<=reg1_i*reg2_i as a 64-bit unsigned product, written at the edge. No stall.
- MULT on accept: same timing, with signed 64-bit product.
- An instruction in the cycle after any of these writes sees the new HI/LO. Ordering between these writes and MFHI/MFLO therefore needs no forwarding.
- MFHI/MFLO: combinational read of the register values; no state change.
- Any other aluop: no effect.
- FSM states: IDLE, RUN, DONE.
- IDLE + accept + DIV/DIVU + reg2_i!=0:
  - stallreq_o=1 combinationally in this cycle.
  - Latch |dividend| and |divisor| (signed op) or raw values (unsigned).
  - Latch the negate-quotient flag = sign1 XOR sign2, and the negate-remainder flag = sign1 (signed only).
  - Clear the remainder accumulator; cnt<=0; go to RUN.
- RUN: stallreq_o=1. Each cycle does one restoring step:
  - shift {rem,quo} left 1
  - trial = rem - divisor (33-bit)
  - if trial is non-negative: rem=trial, quo[0]=1
  - cnt increments; after DIV_CYCLES steps go to DONE.
- DONE: stallreq_o=0, so the pipeline advances on this edge.
  - lo_q<=quotient and hi_q<=remainder, each negated (two's complement) if its flag is set.
  - Return to IDLE.
  - The DIV instruction still present on aluop_i in DONE must not restart a divide.
- Stall length of a non-zero divide: 33 cycles with stallreq_o=1 (issue cycle plus 32 RUN cycles), then 1 DONE cycle.
- Divide by zero (reg2_i==0), DIV or DIVU: completes in the issue cycle with no stall. hi_q<=reg1_i, lo_q<=32'hFFFFFFFF.
- Signed 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (magnitude wraps, no trap).
- Signed remainder takes the sign of the dividend. Quotient truncates toward zero.
- flush_i=1 in any state: FSM->IDLE at the edge, stallreq_o=0 in that cycle, HI/LO unchanged, and no accept that cycle.
- Reset mid-divide: immediate return to IDLE with HI/LO=0.
- valid_i=0 in IDLE: no action.
- Decode keeps valid_i and aluop_i stable while stallreq_o=1. The divider uses only latched operands after the issue cycle.

Test Plan:
- Reset then MTHI reg1=0x12345678, then MFHI -> hilo_rdata_o=0x12345678 in the next cycle; lo_o=0.
- MULT 0xFFFFFFFE * 0x00000003 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU of the same operands -> hi=0x00000002, lo=0xFFFFFFFA. Neither raises stallreq_o.
- DIV -7 / 2 -> stallreq_o high for exactly 33 cycles, then DONE; lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/7 -> lo=14, hi=2.
- DIVU 5/0 -> no stall, hi=5, lo=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- Start DIVU 100/7 with HI/LO preloaded to 0xAAAA/0xBBBB, assert flush_i at RUN cycle 10 -> stallreq_o drops that cycle, HI/LO stay 0xAAAA/0xBBBB, and a following MTLO 0x1 is accepted immediately.
- Assert rst asynchronously mid-RUN -> stallreq_o=0 and hi_o=lo_o=0 before the next clock edge; a subsequent DIVU 9/3 gives lo=3, hi=0.
